usr_frame_rx: RTL and testbench

- Downstream consumer of the 4-bit universal shift register's serial output (SO).
- Deframes the serial bitstream into parallel words using the frame: start bit, DATA_W data bits LSB first, even parity bit, stop bit.
- Delivers each word over a valid/ready output buffer and flags parity, framing and overrun errors.
- Bits advance only on cycles where bit_en is high, which matches the cycles where the upstream register performs a shift.

---
 rtl/usr_frame_rx.sv | 174 +++++++++++++++++
 tb/tb_usr_frame_rx.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/usr_frame_rx.sv
// -----------------------------------------------------------------------------
// usr_frame_rx
//   Deframes the serial output of the universal shift register into parallel
//   words. The frame is a start bit (1), then DATA_W data bits LSB first, then
//   an even parity bit, then a stop bit (0). The line idles at 0. One bit is
//   consumed on each cycle where bit_en is high. Every other cycle is ignored.
//
//   Each received word is held in a single-entry valid/ready output buffer.
//   Error status is reported in three ways:
//     - parity_err travels with the word.
//     - frame_err is a one-cycle pulse when the stop bit is bad.
//     - overrun is a one-cycle pulse when a good frame is dropped because
//       the buffer is still full.
//
// Ports
//   clk        : rising-edge clock
//   rst        : asynchronous active-high reset
//   bit_en     : sample strobe, one serial bit per high cycle
//   si         : serial line (upstream SO)
//   data_out   : received word, meaningful while data_valid is high
//   parity_err : parity status of data_out, meaningful while data_valid is high
//   data_valid : output buffer holds an unconsumed word
//   data_ready : consumer accepts the word when data_valid & data_ready
//   frame_err  : one-cycle pulse on a bad stop bit
//   overrun    : one-cycle pulse when a good frame is dropped (buffer full)
//   busy       : registered decode of (state != IDLE)
// -----------------------------------------------------------------------------
module usr_frame_rx #(
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bit_en,
  input  logic              si,
  output logic [DATA_W-1:0] data_out,
  output logic              parity_err,
  output logic              data_valid,
  input  logic              data_ready,
  output logic              frame_err,
  output logic              overrun,
  output logic              busy
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q;
  logic [DATA_W-1:0]   shreg_q;
  logic [DATA_W-1:0]   shreg_shifted;
  logic                perr_q;
  logic                buf_free;
  logic                load;
  logic                frame_err_d;
  logic                overrun_d;

  // The buffer can take a new word if it is empty, or if its current word
  // is being accepted on this same edge.
  assign buf_free = !data_valid || data_ready;

  // Right shift with si entering at the MSB. After DATA_W shifts, the first
  // data bit sits at bit 0. This form is written so that it stays legal
  // when DATA_W is 1.
  assign shreg_shifted = (shreg_q >> 1) | (DATA_W'(si) << (DATA_W - 1));

  // ---------------------------------------------------------------------------
  // Next-state and event decode
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path
    // leaves one unassigned and no latch is inferred.
    state_d     = state_q;
    load        = 1'b0;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;

    if (bit_en) begin
      case (state_q)
        IDLE: begin
          if (si) state_d = DATA;
        end
        DATA: begin
          if (cnt_q == CNT_W'(DATA_W - 1)) state_d = PARITY;
        end
        PARITY: begin
          state_d = STOP;
        end
        STOP: begin
          // The stop bit always ends the frame. A 1 here is a framing error
          // and is never taken as the start of the next frame.
          state_d = IDLE;
          if (si)            frame_err_d = 1'b1;
          else if (buf_free) load        = 1'b1;
          else               overrun_d   = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // State register and busy decode
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments, so every register
    // samples the values from before the edge and ordering between blocks
    // cannot matter.
    if (rst) begin
      state_q <= IDLE;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      busy    <= (state_d != IDLE);
    end
  end

  // ---------------------------------------------------------------------------
  // Bit counter, shift register and parity capture
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      shreg_q <= '0;
      perr_q  <= 1'b0;
    end else if (bit_en) begin
      case (state_q)
        IDLE: begin
          if (si) cnt_q <= '0;
        end
        DATA: begin
          shreg_q <= shreg_shifted;
          cnt_q   <= cnt_q + CNT_W'(1);
        end
        PARITY: begin
          // An odd number of ones across data and parity means an error.
          perr_q <= (^shreg_q) ^ si;
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Output buffer and error pulses
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out   <= '0;
      parity_err <= 1'b0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_err <= frame_err_d;
      overrun   <= overrun_d;
      if (load) begin
        // A load on the same edge as an accept replaces the word.
        // In that case data_valid stays high.
        data_out   <= shreg_q;
        parity_err <= perr_q;
        data_valid <= 1'b1;
      end else if (data_valid && data_ready) begin
        data_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_usr_frame_rx.sv
// -----------------------------------------------------------------------------
// tb_usr_frame_rx
//   Self-checking bench for usr_frame_rx (DATA_W = 4).
//
//   The reference model works at frame level. Enabled bits are collected
//   into a queue once a start bit is seen in idle. When DATA_W+2 bits have
//   been collected, the frame is judged as a whole. A single-entry buffer
//   model then decides what happens to the word: load, overrun or frame
//   error.
//
//   Inputs are driven just after the falling edge. Outputs are compared at
//   the next falling edge.
// -----------------------------------------------------------------------------
module tb_usr_frame_rx;

  localparam int DW = 4;

  logic          clk;
  logic          rst;
  logic          bit_en;
  logic          si;
  logic [DW-1:0] data_out;
  logic          parity_err;
  logic          data_valid;
  logic          data_ready;
  logic          frame_err;
  logic          overrun;
  logic          busy;

  int n_cmp = 0;
  int n_err = 0;

  usr_frame_rx #(.DATA_W(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .bit_en     (bit_en),
    .si         (si),
    .data_out   (data_out),
    .parity_err (parity_err),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Reference model state
  // ---------------------------------------------------------------------------
  bit            m_in_frame;
  bit            m_frame[$];
  bit            m_valid;
  bit [DW-1:0]   m_data;
  bit            m_perr;
  bit            m_ferr;
  bit            m_ovr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_in_frame = 1'b0;
    m_frame.delete();
    m_valid = 1'b0;
    m_data  = '0;
    m_perr  = 1'b0;
    m_ferr  = 1'b0;
    m_ovr   = 1'b0;
  endtask

  // Advance the model by one clock edge, using the inputs presented before it.
  task automatic model_step(input bit en, input bit s, input bit rdy);
    bit          old_valid;
    bit [DW-1:0] word;
    int          ones;
    old_valid = m_valid;
    m_ferr = 1'b0;
    m_ovr  = 1'b0;
    if (old_valid && rdy) m_valid = 1'b0;
    if (en) begin
      if (!m_in_frame) begin
        if (s) begin
          m_in_frame = 1'b1;
          m_frame.delete();
        end
      end else begin
        m_frame.push_back(s);
        if (m_frame.size() == DW + 2) begin
          m_in_frame = 1'b0;
          word = '0;
          ones = 0;
          for (int i = 0; i < DW; i++) word[i] = m_frame[i];
          for (int i = 0; i <= DW; i++) ones += int'(m_frame[i]);
          if (m_frame[DW+1]) begin
            m_ferr = 1'b1;
          end else if (!old_valid || rdy) begin
            m_valid = 1'b1;
            m_data  = word;
            m_perr  = (ones % 2) != 0;
          end else begin
            m_ovr = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".valid"}, data_valid, m_valid);
    if (m_valid) begin
      check({tag, ".data"}, data_out, m_data);
      check({tag, ".perr"}, parity_err, m_perr);
    end
    check({tag, ".ferr"}, frame_err, m_ferr);
    check({tag, ".ovr"},  overrun,   m_ovr);
    check({tag, ".busy"}, busy,      m_in_frame);
  endtask

  // One clock cycle. The caller must be at a falling edge.
  task automatic step(input bit en, input bit s, input bit rdy, input string tag);
    bit_en     = en;
    si         = s;
    data_ready = rdy;
    model_step(en, s, rdy);
    @(posedge clk);
    @(negedge clk);
    compare_all(tag);
  endtask

  // Reset is asynchronous, so the outputs must clear before any clock edge.
  task automatic do_reset(input string tag);
    bit_en     = 1'b0;
    si         = 1'b0;
    data_ready = 1'b0;
    rst        = 1'b1;
    #1;
    check({tag, ".rst_out"},   data_out,   '0);
    check({tag, ".rst_perr"},  parity_err, 1'b0);
    check({tag, ".rst_valid"}, data_valid, 1'b0);
    check({tag, ".rst_ferr"},  frame_err,  1'b0);
    check({tag, ".rst_ovr"},   overrun,    1'b0);
    check({tag, ".rst_busy"},  busy,       1'b0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Send a complete frame.
  //   gap      : disabled cycles (carrying random si) before each enabled bit
  //   rdy      : data_ready on every cycle except the stop-bit cycle
  //   rdy_stop : data_ready on the stop-bit cycle
  //   rnd_rdy  : randomise data_ready on every cycle instead
  task automatic send_frame(input bit [DW-1:0] word, input bit pbit, input bit stop,
                            input int gap, input bit rdy, input bit rdy_stop,
                            input bit rnd_rdy, input string tag);
    bit bits[$];
    bit r;
    bits.push_back(1'b1);
    for (int i = 0; i < DW; i++) bits.push_back(word[i]);
    bits.push_back(pbit);
    bits.push_back(stop);
    for (int b = 0; b < bits.size(); b++) begin
      r = (b == bits.size() - 1) ? rdy_stop : rdy;
      for (int g = 0; g < gap; g++)
        step(1'b0, 1'($urandom), rnd_rdy ? 1'($urandom) : r, tag);
      step(1'b1, bits[b], rnd_rdy ? 1'($urandom) : r, tag);
    end
  endtask

  initial begin
    bit_en     = 1'b0;
    si         = 1'b0;
    data_ready = 1'b0;
    rst        = 1'b1;
    model_reset();
    do_reset("init");

    // 1: 4'hA with even parity; the word is then drained with data_ready.
    send_frame(4'hA, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, "s1");
    check("s1.word", data_out, 4'hA);
    check("s1.up",   data_valid, 1'b1);
    step(1'b0, 1'b0, 1'b1, "s1_drain");

    // 2: parity bit 1 makes the frame odd.
    send_frame(4'hA, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0, "s2");
    check("s2.perr", parity_err, 1'b1);
    step(1'b0, 1'b0, 1'b1, "s2_drain");

    // 3: bad stop bit, then a good 4'h3.
    send_frame(4'h3, 1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b0, "s3_bad");
    check("s3.ferr", frame_err, 1'b1);
    step(1'b0, 1'b0, 1'b0, "s3_idle");
    send_frame(4'h3, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, "s3_good");
    check("s3.word", data_out, 4'h3);
    step(1'b0, 1'b0, 1'b1, "s3_drain");

    // 4: overrun with data_ready held low, then replace on the stop-bit accept.
    send_frame(4'hA, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, "s4_a");
    send_frame(4'h5, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, "s4_b");
    check("s4.ovr",  overrun, 1'b1);
    check("s4.keep", data_out, 4'hA);
    send_frame(4'h5, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0, "s4_c");
    check("s4.repl", data_out, 4'h5);
    check("s4.novr", overrun, 1'b0);
    step(1'b0, 1'b0, 1'b1, "s4_drain");

    // 5: bit_en every third cycle, with noise on the disabled cycles.
    send_frame(4'hA, 1'b0, 1'b0, 2, 1'b0, 1'b0, 1'b0, "s5");
    check("s5.word", data_out, 4'hA);
    step(1'b0, 1'b0, 1'b1, "s5_drain");

    // 6: reset after three data bits, then a clean 4'h3.
    step(1'b1, 1'b1, 1'b0, "s6_start");
    for (int i = 0; i < 3; i++) step(1'b1, 1'($urandom), 1'b0, "s6_bits");
    do_reset("s6");
    send_frame(4'h3, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, "s6_after");
    check("s6.word", data_out, 4'h3);
    step(1'b0, 1'b0, 1'b1, "s6_drain");

    // Random frames: random word, parity, occasional bad stop bit, gaps, ready.
    for (int f = 0; f < 60; f++) begin
      send_frame(4'($urandom), 1'($urandom), ($urandom_range(0, 4) == 0),
                 $urandom_range(0, 2), 1'b0, 1'b0, 1'b1, "rnd_frame");
      for (int k = 0; k < $urandom_range(0, 3); k++)
        step(1'($urandom), 1'b0, 1'($urandom), "rnd_idle");
    end

    // Unstructured random line traffic.
    for (int c = 0; c < 600; c++)
      step(1'($urandom), 1'($urandom), 1'($urandom), "rnd_line");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
